serial_rx: RTL and testbench

- Receive end of the display serial link: decodes sclk / data_enable / sdo / dclk as driven by the serial shifter and recovers the parallel word.
- Used as a loopback checker on spare GPIO and as the front end of a future board-to-board link.
- All four link inputs are treated as asynchronous. They are oversampled in the internal oscillator domain. The link runs at int_osc/512, so the oversampling margin is large.

---
 rtl/serial_rx.sv | 163 ++++++++++++++++
 tb/tb_serial_rx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// serial_rx: receive end of the display serial link.
// Oversamples the asynchronous sclk / data_enable / sdo / dclk lines in the
// internal oscillator domain, shifts payload bits in MSB first on each sclk
// rise, and commits the recovered word on a dclk rise when exactly WIDTH
// bits have been collected. Any other commit is reported as a frame error.
module serial_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       data_enable,
    input  logic                       sdo,
    input  logic                       dclk,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    output logic                       frame_err,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(WIDTH);

    // Bit positions of the link lines inside the synchronizer bundle.
    localparam int SCLK_B = 0;
    localparam int EN_B   = 1;
    localparam int SDO_B  = 2;
    localparam int DCLK_B = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    state_t                         state_r;
    logic [WIDTH-1:0]               shift_r;

    logic [3:0]                     link_s;
    logic [SYNC_STAGES-1:0][3:0]    sync_r;
    logic [3:0]                     sync_out_s;
    logic [2:0]                     hist_r;      // {dclk, data_enable, sclk}

    logic                           sclk_rise_s;
    logic                           en_rise_s;
    logic                           dclk_rise_s;

    // Registered event stage: all events and the sampled sdo/enable levels
    // are captured together so that they stay aligned cycle for cycle.
    logic                           sclk_rise_r;
    logic                           en_rise_r;
    logic                           dclk_rise_r;
    logic                           sdo_d_r;
    logic                           en_lvl_r;

    assign link_s     = {dclk, sdo, data_enable, sclk};
    assign sync_out_s = sync_r[SYNC_STAGES-1];

    assign sclk_rise_s = sync_out_s[SCLK_B] & ~hist_r[0];
    assign en_rise_s   = sync_out_s[EN_B]   & ~hist_r[1];
    assign dclk_rise_s = sync_out_s[DCLK_B] & ~hist_r[2];

    assign busy = (state_r != IDLE);

    // Synchronizer chain for all four link lines (same depth, so sdo and
    // sclk see identical delay) followed by the edge-history flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= '0;
            hist_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], link_s};
            hist_r <= {sync_out_s[DCLK_B], sync_out_s[EN_B], sync_out_s[SCLK_B]};
        end
    end

    // Capture the rise events with the sdo and enable levels of the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_rise_r <= 1'b0;
            en_rise_r   <= 1'b0;
            dclk_rise_r <= 1'b0;
            sdo_d_r     <= 1'b0;
            en_lvl_r    <= 1'b0;
        end else begin
            sclk_rise_r <= sclk_rise_s;
            en_rise_r   <= en_rise_s;
            dclk_rise_r <= dclk_rise_s;
            sdo_d_r     <= sync_out_s[SDO_B];
            en_lvl_r    <= sync_out_s[EN_B];
        end
    end

    // Frame FSM: shifting, bit counting, commit / reject on dclk.
    // dclk has priority over a coincident sclk rise (that bit is dropped);
    // a coincident enable rise starts a fresh frame after the commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            bit_count  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (dclk_rise_r) begin
                if ((state_r == SHIFT) && (bit_count == FULL_C)) begin
                    data_out   <= shift_r;
                    data_valid <= 1'b1;
                end else begin
                    frame_err  <= 1'b1;
                end
                bit_count <= '0;
                if (en_rise_r) begin
                    state_r <= SHIFT;
                    shift_r <= '0;
                end else begin
                    state_r <= IDLE;
                end
            end else if (en_rise_r) begin
                // Fresh frame from any state; a restart is not an error.
                state_r   <= SHIFT;
                bit_count <= '0;
                shift_r   <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    SHIFT: begin
                        if (sclk_rise_r && en_lvl_r) begin
                            shift_r <= {shift_r[WIDTH-2:0], sdo_d_r};
                            if (bit_count == FULL_C) begin
                                state_r <= OVERRUN;
                            end else begin
                                bit_count <= bit_count + CW'(1);
                            end
                        end else begin
                            state_r <= SHIFT;
                        end
                    end
                    OVERRUN: begin
                        // Keep the most recent WIDTH bits; count stays saturated.
                        if (sclk_rise_r && en_lvl_r) begin
                            shift_r <= {shift_r[WIDTH-2:0], sdo_d_r};
                        end else begin
                            state_r <= OVERRUN;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        bit_count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_rx.sv
// Directed testbench for serial_rx: one task per scenario, inline checks.
module tb_serial_rx;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        data_enable;
    logic        sdo;
    logic        dclk;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic [5:0]  bit_count;
    logic        busy;

    int n_checks;
    int n_fail;

    serial_rx #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .data_enable (data_enable),
        .sdo         (sdo),
        .dclk        (dclk),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .bit_count   (bit_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One sclk period: sdo set during low phase, then sclk high for half clk.
    task automatic send_bit(input logic b, input int half);
        @(negedge clk);
        sdo = b;
        repeat (half) @(negedge clk);
        sclk = 1'b1;
        repeat (half) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            send_bit(w[31-i], half);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        data_enable = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        data_enable = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Pulse dclk and count cycles with data_valid / frame_err / both high.
    task automatic pulse_dclk(output int nv, output int ne, output int nb);
        nv = 0;
        ne = 0;
        nb = 0;
        @(negedge clk);
        dclk = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (data_valid === 1'b1) nv++;
            if (frame_err === 1'b1) ne++;
            if ((data_valid === 1'b1) && (frame_err === 1'b1)) nb++;
        end
        @(negedge clk);
        dclk = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out got %h exp 0", data_out); end
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid got %b exp 0", data_valid); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        n_checks++;
        if (bit_count !== 6'd0) begin n_fail++; $display("FAIL reset_bit_count got %0d exp 0", bit_count); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_nominal();
        logic exp_v;
        start_frame();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL nom_busy_start got %b exp 1", busy); end
        send_word(32'hF0F00F0F, 32, 256);
        n_checks++;
        if (bit_count !== 6'd32) begin n_fail++; $display("FAIL nom_bit_count got %0d exp 32", bit_count); end
        @(negedge clk);
        dclk = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            exp_v = (e == 4) ? 1'b1 : 1'b0;
            n_checks++;
            if (data_valid !== exp_v) begin
                n_fail++;
                $display("FAIL nom_latency_valid edge %0d got %b exp %b", e, data_valid, exp_v);
            end
            n_checks++;
            if (frame_err !== 1'b0) begin
                n_fail++;
                $display("FAIL nom_frame_err edge %0d got %b exp 0", e, frame_err);
            end
        end
        @(negedge clk);
        dclk = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (data_out !== 32'hF0F00F0F) begin n_fail++; $display("FAIL nom_data_out got %h exp f0f00f0f", data_out); end
        n_checks++;
        if (bit_count !== 6'd0) begin n_fail++; $display("FAIL nom_count_after got %0d exp 0", bit_count); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL nom_busy_after got %b exp 0", busy); end
        end_frame();
    endtask

    task automatic test_reset_mid_frame();
        int nv, ne, nb;
        start_frame();
        send_word(32'hFFC00000, 10, 8);
        n_checks++;
        if (bit_count !== 6'd10) begin n_fail++; $display("FAIL rmf_count_before got %0d exp 10", bit_count); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rmf_busy_before got %b exp 1", busy); end
        @(negedge clk);
        data_enable = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (data_out !== 32'h0) begin n_fail++; $display("FAIL rmf_data_out got %h exp 0", data_out); end
        n_checks++;
        if (bit_count !== 6'd0) begin n_fail++; $display("FAIL rmf_count got %0d exp 0", bit_count); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmf_busy got %b exp 0", busy); end
        nv = 0;
        ne = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (data_valid === 1'b1) nv++;
            if (frame_err === 1'b1) ne++;
        end
        n_checks++;
        if ((nv + ne) !== 0) begin n_fail++; $display("FAIL rmf_no_pulse got %0d pulses exp 0", nv + ne); end
        start_frame();
        send_word(32'h12345678, 32, 8);
        pulse_dclk(nv, ne, nb);
        n_checks++;
        if (nv !== 1) begin n_fail++; $display("FAIL rmf_valid_count got %0d exp 1", nv); end
        n_checks++;
        if (ne !== 0) begin n_fail++; $display("FAIL rmf_err_count got %0d exp 0", ne); end
        n_checks++;
        if (data_out !== 32'h12345678) begin n_fail++; $display("FAIL rmf_data_out_after got %h exp 12345678", data_out); end
        end_frame();
    endtask

    task automatic test_back_to_back();
        int nv, ne, nb;
        int tv;
        tv = 0;
        start_frame();
        send_word(32'hF0F00F0F, 32, 8);
        pulse_dclk(nv, ne, nb);
        tv += nv;
        n_checks++;
        if (data_out !== 32'hF0F00F0F) begin n_fail++; $display("FAIL b2b_first got %h exp f0f00f0f", data_out); end
        end_frame();
        start_frame();
        send_word(32'h0F0FF0F0, 32, 8);
        pulse_dclk(nv, ne, nb);
        tv += nv;
        n_checks++;
        if (tv !== 2) begin n_fail++; $display("FAIL b2b_valid_pulses got %0d exp 2", tv); end
        n_checks++;
        if (ne !== 0) begin n_fail++; $display("FAIL b2b_err got %0d exp 0", ne); end
        n_checks++;
        if (data_out !== 32'h0F0FF0F0) begin n_fail++; $display("FAIL b2b_second got %h exp 0f0ff0f0", data_out); end
        end_frame();
    endtask

    task automatic test_short_frame();
        int nv, ne, nb;
        start_frame();
        send_word(32'hDEADBEEF, 31, 8);
        n_checks++;
        if (bit_count !== 6'd31) begin n_fail++; $display("FAIL short_count_before got %0d exp 31", bit_count); end
        pulse_dclk(nv, ne, nb);
        n_checks++;
        if (ne !== 1) begin n_fail++; $display("FAIL short_err got %0d exp 1", ne); end
        n_checks++;
        if (nv !== 0) begin n_fail++; $display("FAIL short_valid got %0d exp 0", nv); end
        n_checks++;
        if (data_out !== 32'h0F0FF0F0) begin n_fail++; $display("FAIL short_data_out got %h exp 0f0ff0f0", data_out); end
        n_checks++;
        if (bit_count !== 6'd0) begin n_fail++; $display("FAIL short_count_after got %0d exp 0", bit_count); end
        end_frame();
    endtask

    task automatic test_overrun();
        int nv, ne, nb;
        start_frame();
        send_word(32'h3C3CA5A5, 32, 8);
        send_bit(1'b1, 8);
        n_checks++;
        if (bit_count !== 6'd32) begin n_fail++; $display("FAIL ovr_count_sat got %0d exp 32", bit_count); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy got %b exp 1", busy); end
        pulse_dclk(nv, ne, nb);
        n_checks++;
        if (ne !== 1) begin n_fail++; $display("FAIL ovr_err got %0d exp 1", ne); end
        n_checks++;
        if (nv !== 0) begin n_fail++; $display("FAIL ovr_valid got %0d exp 0", nv); end
        n_checks++;
        if (nb !== 0) begin n_fail++; $display("FAIL ovr_both_high got %0d exp 0", nb); end
        n_checks++;
        if (data_out !== 32'h0F0FF0F0) begin n_fail++; $display("FAIL ovr_data_out got %h exp 0f0ff0f0", data_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ovr_idle got busy %b exp 0", busy); end
        end_frame();
    endtask

    task automatic test_enable_drop();
        int nv, ne, nb;
        start_frame();
        send_word(32'hA5C31E69, 32, 8);
        @(negedge clk);
        data_enable = 1'b0;
        repeat (8) @(negedge clk);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        n_checks++;
        if (bit_count !== 6'd32) begin n_fail++; $display("FAIL edrop_count got %0d exp 32", bit_count); end
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL edrop_busy got %b exp 1", busy); end
        pulse_dclk(nv, ne, nb);
        n_checks++;
        if (nv !== 1) begin n_fail++; $display("FAIL edrop_valid got %0d exp 1", nv); end
        n_checks++;
        if (ne !== 0) begin n_fail++; $display("FAIL edrop_err got %0d exp 0", ne); end
        n_checks++;
        if (data_out !== 32'hA5C31E69) begin n_fail++; $display("FAIL edrop_data_out got %h exp a5c31e69", data_out); end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        sclk        = 1'b0;
        data_enable = 1'b0;
        sdo         = 1'b0;
        dclk        = 1'b0;
        test_reset();
        test_nominal();
        test_reset_mid_frame();
        test_back_to_back();
        test_short_frame();
        test_overrun();
        test_enable_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
